multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 36 +++
 rtl/multicycle_ctrl_op_classifier.sv | 30 +++
 rtl/multicycle_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, operation
// classes, decoder-index boundaries and write-back source selects.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU     = 3'd0,
    C_LOAD    = 3'd1,
    C_STORE   = 3'd2,
    C_BRANCH  = 3'd3,
    C_JUMP    = 3'd4,
    C_ILLEGAL = 3'd5
  } op_class_t;

  // First index of each class range in the decoder ROM
  localparam int unsigned OP_LOAD_FIRST   = 19;
  localparam int unsigned OP_STORE_FIRST  = 24;
  localparam int unsigned OP_BRANCH_FIRST = 27;
  localparam int unsigned OP_LUI          = 39;
  localparam int unsigned OP_JAL          = 41;
  localparam int unsigned OP_LAST         = 42;

  // Write-back source selects
  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_op_classifier.sv
// Combinational decoder-index classifier: maps an operation index to its
// class and, for branches, whether the branch is taken.
module op_classifier
  import multicycle_ctrl_pkg::*;
#(
  parameter int WIDTH_OP_LENGTH = 6
) (
  input  logic [WIDTH_OP_LENGTH-1:0] op_idx,
  output op_class_t                  op_class,
  output logic                       taken
);

  // Range compare on the zero-extended index, then the taken-branch subset
  always_comb begin
    int unsigned idx;
    idx = 32'(op_idx);
    if (idx < OP_LOAD_FIRST)        op_class = C_ALU;
    else if (idx < OP_STORE_FIRST)  op_class = C_LOAD;
    else if (idx < OP_BRANCH_FIRST) op_class = C_STORE;
    else if (idx < OP_LUI)          op_class = C_BRANCH;
    else if (idx < OP_JAL)          op_class = C_ALU;
    else if (idx <= OP_LAST)        op_class = C_JUMP;
    else                            op_class = C_ILLEGAL;
    case (idx)
      32'd27, 32'd30, 32'd31, 32'd34, 32'd35, 32'd38: taken = 1'b1;
      default:                                        taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with
// optional performance counters, enabled by defining PERF_COUNTERS_EN.
// Control outputs are decoded combinationally from the state register so an
// asynchronous reset drops MemWe immediately and presents a fetch request.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int WIDTH_OP_LENGTH  = 6,
  parameter int WIDTH_CNT_LENGTH = 32
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [WIDTH_OP_LENGTH-1:0]  OpIdx,
  input  logic                        MemReady,
  output logic                        MemReq,
  output logic                        MemSel,
  output logic                        MemWe,
  output logic                        IRWrite,
  output logic                        PCWrite,
  output logic                        PCSel,
  output logic                        RegWEn,
  output logic [1:0]                  WBSel,
  output logic                        Retire,
  output logic                        Illegal,
  output logic [WIDTH_CNT_LENGTH-1:0] CycleCnt,
  output logic [WIDTH_CNT_LENGTH-1:0] InstRetCnt
);

  state_t                     state;
  logic [WIDTH_OP_LENGTH-1:0] op_q;
  logic [WIDTH_OP_LENGTH-1:0] op_sel;
  op_class_t                  op_class;
  logic                       taken;

  // DECODE classifies the live index; later states use the latched one
  assign op_sel = (state == S_DECODE) ? OpIdx : op_q;

  op_classifier #(.WIDTH_OP_LENGTH(WIDTH_OP_LENGTH)) u_cls (
    .op_idx   (op_sel),
    .op_class (op_class),
    .taken    (taken)
  );

  // State sequencing and operation latch
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= S_FETCH;
      op_q  <= '0;
    end else begin
      case (state)
        S_FETCH:  if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          op_q  <= OpIdx;
          state <= (op_class == C_ILLEGAL) ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          case (op_class)
            C_ALU, C_JUMP:    state <= S_WB;
            C_LOAD, C_STORE:  state <= S_MEM;
            default:          state <= S_FETCH;
          endcase
        end
        S_MEM:    if (MemReady) state <= (op_class == C_LOAD) ? S_WB : S_FETCH;
        S_WB:     state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Control decode; IRWrite is masked under reset so a ready memory cannot
  // load the IR while the unit is being reset.
  always_comb begin
    MemReq  = 1'b0;
    MemSel  = 1'b0;
    MemWe   = 1'b0;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    PCSel   = 1'b0;
    RegWEn  = 1'b0;
    WBSel   = WB_MEM;
    Retire  = 1'b0;
    Illegal = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq  = 1'b1;
        IRWrite = MemReady & ~Rst;
      end
      S_EXEC: begin
        if (op_class == C_BRANCH) begin
          PCWrite = 1'b1;
          PCSel   = taken;
          Retire  = 1'b1;
        end
      end
      S_MEM: begin
        MemReq = 1'b1;
        MemSel = 1'b1;
        MemWe  = (op_class == C_STORE);
        if (MemReady && op_class == C_STORE) begin
          PCWrite = 1'b1;
          Retire  = 1'b1;
        end
      end
      S_WB: begin
        RegWEn  = 1'b1;
        PCWrite = 1'b1;
        Retire  = 1'b1;
        PCSel   = (op_class == C_JUMP);
        case (op_class)
          C_LOAD:  WBSel = WB_MEM;
          C_JUMP:  WBSel = WB_PC4;
          default: WBSel = WB_ALU;
        endcase
      end
      S_TRAP:  Illegal = 1'b1;
      default: ;
    endcase
  end

`ifdef PERF_COUNTERS_EN
  logic [WIDTH_CNT_LENGTH-1:0] cycle_q;
  logic [WIDTH_CNT_LENGTH-1:0] ret_q;

  // Free-running cycle count and retired-instruction count, both wrapping
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cycle_q <= '0;
      ret_q   <= '0;
    end else begin
      cycle_q <= cycle_q + WIDTH_CNT_LENGTH'(1);
      if (Retire) ret_q <= ret_q + WIDTH_CNT_LENGTH'(1);
    end
  end

  assign CycleCnt   = cycle_q;
  assign InstRetCnt = ret_q;
`else
  assign CycleCnt   = '0;
  assign InstRetCnt = '0;
`endif

endmodule
